reg_bank8: RTL and testbench

REG_BANK8 -- requirements
Module: reg_bank8

---
 rtl/reg_bank8.sv | 133 +++++++++++++
 tb/tb_reg_bank8.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank8.sv
// Eight 8-bit registers with per-register pending (scoreboard) flags, a pending
// count, same-cycle issue/write-back arbitration and a sticky stray-write flag.
module reg_bank8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic       issue,
    input  logic [2:0] issue_addr,
    input  logic [2:0] rsel,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3,
    output logic [7:0] r4,
    output logic [7:0] r5,
    output logic [7:0] r6,
    output logic [7:0] r7,
    output logic [7:0] pend,
    output logic [3:0] pend_cnt,
    output logic       hazard,
    output logic       issue_stall,
    output logic       err_stray
);

    localparam int unsigned NREGS = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 4;

    logic [DW-1:0]    regs_q [NREGS];
    logic [DW-1:0]    regs_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [CW-1:0]    pend_cnt_q;
    logic [CW-1:0]    pend_cnt_d;
    logic             err_stray_q;
    logic             err_stray_d;

    logic             same_idx;
    logic             issue_ok;
    logic             cnt_inc;
    logic             cnt_dec;

    // A write-back to the same index frees the slot, so that issue is not stalled.
    always_comb begin
        same_idx    = we && (waddr == issue_addr);
        issue_stall = issue && pend_q[issue_addr] && !same_idx;
        issue_ok    = issue && !issue_stall;
        hazard      = pend_q[rsel];
    end

    // Data registers: write-back only, no bypass.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Clear on write-back first, then set on issue so a same-index issue wins.
    always_comb begin
        pend_d = pend_q;
        if (we) begin
            pend_d[waddr] = 1'b0;
        end
        if (issue_ok) begin
            pend_d[issue_addr] = 1'b1;
        end
    end

    // Count tracks bit transitions; a same-index clear+set leaves the bit set.
    always_comb begin
        cnt_inc    = issue_ok && !pend_q[issue_addr];
        cnt_dec    = we && pend_q[waddr] && !(issue_ok && same_idx);
        pend_cnt_d = pend_cnt_q;
        unique case ({cnt_inc, cnt_dec})
            2'b10: begin
                if (pend_cnt_q != CW'(NREGS)) begin
                    pend_cnt_d = pend_cnt_q + CW'(1);
                end
            end
            2'b01: begin
                if (pend_cnt_q != CW'(0)) begin
                    pend_cnt_d = pend_cnt_q - CW'(1);
                end
            end
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    always_comb begin
        err_stray_d = err_stray_q;
        if (we && !pend_q[waddr]) begin
            err_stray_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            pend_q      <= '0;
            pend_cnt_q  <= '0;
            err_stray_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            err_stray_q <= err_stray_d;
        end
    end

    always_comb begin
        r0        = regs_q[0];
        r1        = regs_q[1];
        r2        = regs_q[2];
        r3        = regs_q[3];
        r4        = regs_q[4];
        r5        = regs_q[5];
        r6        = regs_q[6];
        r7        = regs_q[7];
        pend      = pend_q;
        pend_cnt  = pend_cnt_q;
        err_stray = err_stray_q;
    end

endmodule

// File: tb/tb_reg_bank8.sv
// Scoreboard bench for reg_bank8: directed vectors push expectations, a
// negedge monitor pops and compares against the DUT outputs.
module tb_reg_bank8;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       issue;
    logic [2:0] issue_addr;
    logic [2:0] rsel;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0] pend;
    logic [3:0] pend_cnt;
    logic       hazard;
    logic       issue_stall;
    logic       err_stray;

    reg_bank8 dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .issue(issue), .issue_addr(issue_addr), .rsel(rsel),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .pend(pend), .pend_cnt(pend_cnt), .hazard(hazard),
        .issue_stall(issue_stall), .err_stray(err_stray)
    );

    typedef struct {
        logic [63:0] r;
        logic [7:0]  pend;
        logic [3:0]  cnt;
        logic        err;
        logic        haz;
        logic        stall;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_mis = 0;

    logic [7:0]  m_r [8];
    logic [7:0]  m_pend;
    logic        m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rvec();
        return {r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    function automatic void cmp(string nm, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Monitor: compare one expectation per cycle, discard anything queued during reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            cmp("sb_r",     rvec(),                 mon_e.r);
            cmp("sb_pend",  64'(pend),              64'(mon_e.pend));
            cmp("sb_cnt",   64'(pend_cnt),          64'(mon_e.cnt));
            cmp("sb_err",   64'(err_stray),         64'(mon_e.err));
            cmp("sb_haz",   64'(hazard),            64'(mon_e.haz));
            cmp("sb_stall", 64'(issue_stall),       64'(mon_e.stall));
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_pend = 8'h00;
        m_err  = 1'b0;
    endtask

    // Called just after a rising edge: drive inputs, queue the expectation, take the edge.
    task automatic step(input logic i_we, input logic [2:0] i_wa, input logic [7:0] i_wd,
                        input logic i_is, input logic [2:0] i_ia, input logic [2:0] i_rs);
        exp_t e;
        logic stall;
        we = i_we; waddr = i_wa; wdata = i_wd;
        issue = i_is; issue_addr = i_ia; rsel = i_rs;
        stall = i_is && m_pend[i_ia] && !(i_we && (i_wa == i_ia));
        for (int i = 0; i < 8; i++) e.r[i*8 +: 8] = m_r[i];
        e.pend  = m_pend;
        e.cnt   = 4'($countones(m_pend));
        e.err   = m_err;
        e.haz   = m_pend[i_rs];
        e.stall = stall;
        sb.push_back(e);
        @(posedge clk);
        if (i_we) begin
            m_r[i_wa] = i_wd;
            if (!m_pend[i_wa]) m_err = 1'b1;
            m_pend[i_wa] = 1'b0;
        end
        if (i_is && !stall) m_pend[i_ia] = 1'b1;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    endtask

    // Asynchronous reset between edges with busy inputs that must be ignored.
    task automatic reset_mid();
        #2;
        we = 1'b1; waddr = 3'd6; wdata = 8'hFF; issue = 1'b1; issue_addr = 3'd6;
        rst_n = 1'b0;
        #1;
        cmp("rst_async_r",    rvec(),          64'h0);
        cmp("rst_async_pend", 64'(pend),       64'h0);
        cmp("rst_async_cnt",  64'(pend_cnt),   64'h0);
        cmp("rst_async_err",  64'(err_stray),  64'h0);
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_hold_r",    rvec(),    64'h0);
        cmp("rst_hold_pend", 64'(pend), 64'h0);
        we = 1'b0; issue = 1'b0; wdata = 8'h00; waddr = 3'd0; issue_addr = 3'd0;
        model_clear();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        we = 1'b0; waddr = 3'd0; wdata = 8'h00;
        issue = 1'b0; issue_addr = 3'd0; rsel = 3'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        idle();
        cmp("init_pend", 64'(pend), 64'h0);

        // Stray write to r3.
        step(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd0);
        idle();
        cmp("wr3_r",   rvec(),         64'h00000000_A5000000);
        cmp("wr3_err", 64'(err_stray), 64'h1);

        // Issue 2 and 5, hazard on 5, then write-back 5.
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5);
        cmp("haz_pend", 64'(pend),     64'h24);
        cmp("haz_cnt",  64'(pend_cnt), 64'h2);
        step(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 3'd5);
        cmp("wb5_pend", 64'(pend),     64'h04);
        cmp("wb5_cnt",  64'(pend_cnt), 64'h1);
        cmp("wb5_r5",   64'(r5),       64'h3C);
        cmp("wb5_haz",  64'(hazard),   64'h0);

        // Stall on pending 1, then same-index write-back + issue.
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1);
        cmp("stall_pend", 64'(pend),     64'h06);
        cmp("stall_cnt",  64'(pend_cnt), 64'h2);
        step(1'b1, 3'd1, 8'h7E, 1'b1, 3'd1, 3'd1);
        cmp("swin_r1",   64'(r1),       64'h7E);
        cmp("swin_pend", 64'(pend),     64'h06);
        cmp("swin_cnt",  64'(pend_cnt), 64'h2);

        // Build pend=0F, r6=55, then asynchronous reset mid-cycle.
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd0);
        step(1'b1, 3'd6, 8'h55, 1'b0, 3'd0, 3'd0);
        cmp("pre_rst_pend", 64'(pend), 64'h0F);
        cmp("pre_rst_r6",   64'(r6),   64'h55);
        reset_mid();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd6);
        cmp("post_rst_pend", 64'(pend),     64'h40);
        cmp("post_rst_cnt",  64'(pend_cnt), 64'h1);
        step(1'b1, 3'd6, 8'h99, 1'b0, 3'd0, 3'd6);

        // Fill all eight, then a ninth issue must stall.
        for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 3'(i));
        cmp("full_pend", 64'(pend),     64'hFF);
        cmp("full_cnt",  64'(pend_cnt), 64'h8);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd7);
        cmp("full9_cnt", 64'(pend_cnt), 64'h8);

        // Drain with write-backs.
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(i * 17), 1'b0, 3'd0, 3'(i));
        cmp("drain_pend", 64'(pend),      64'h00);
        cmp("drain_cnt",  64'(pend_cnt),  64'h0);
        cmp("drain_err",  64'(err_stray), 64'h0);

        // Same index, non-pending: write lands, set wins, stray flagged.
        step(1'b1, 3'd4, 8'hC3, 1'b1, 3'd4, 3'd4);
        cmp("nsw_pend", 64'(pend),      64'h10);
        cmp("nsw_cnt",  64'(pend_cnt),  64'h1);
        cmp("nsw_err",  64'(err_stray), 64'h1);
        cmp("nsw_r4",   64'(r4),        64'hC3);

        // Write-back 0 and issue 7 together.
        reset_mid();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0);
        step(1'b1, 3'd0, 8'h11, 1'b1, 3'd7, 3'd0);
        cmp("dual_r0",   64'(r0),        64'h11);
        cmp("dual_pend", 64'(pend),      64'h80);
        cmp("dual_cnt",  64'(pend_cnt),  64'h1);
        cmp("dual_err",  64'(err_stray), 64'h0);
        idle();

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
